// File: rtl/ram_pkg.sv
// Shared definitions for the parity RAM request controller: FSM encoding, default
// geometry and the even-parity helper used on returned read data.
package ram_pkg;

    localparam int unsigned DEF_MEM_WIDTH = 16;
    localparam int unsigned DEF_ADDR_SIZE = 10;

    // Wide enough for WR_HOLD / RD_LATENCY up to 15.
    localparam int unsigned HOLD_CNT_W = 4;

    // Widest data word the parity helper accepts.
    localparam int unsigned PARITY_MAX_W = 64;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // Callers zero-extend narrower words; the extra zeros do not change the result.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 at_max;

    assign at_max = &count_q;

    always_comb begin
        count_d = count_q;
        if (inc && !at_max) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ram_req_ctrl.sv
// Upstream request controller for the parity single-port RAM: one request in flight,
// RAM controls held stable through ACCESS, read data returned with a parity check.
module ram_req_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int unsigned ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int unsigned WR_HOLD    = 3,
    parameter int unsigned RD_LATENCY = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [MEM_WIDTH-1:0] req_wdata,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MEM_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_perr,
    output logic [CNT_WIDTH-1:0] err_count,

    output logic                 ram_blk_select,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic                 ram_addr_en,
    output logic                 ram_dout_en,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0] ram_din,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_parity
);

    localparam logic [HOLD_CNT_W-1:0] WR_LAST = HOLD_CNT_W'(WR_HOLD - 1);
    localparam logic [HOLD_CNT_W-1:0] RD_LAST = HOLD_CNT_W'(RD_LATENCY - 1);

    state_e                state_q, state_d;
    logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;

    logic [ADDR_SIZE-1:0]  addr_q;
    logic [MEM_WIDTH-1:0]  wdata_q;
    logic                  wr_q;
    logic [MEM_WIDTH-1:0]  rdata_q;
    logic                  perr_q;

    logic                  load;
    logic                  capture;
    logic                  perr_now;
    logic                  in_access;

    assign perr_now = even_parity(PARITY_MAX_W'(ram_dout)) != ram_parity;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                cnt_d = cnt_q + HOLD_CNT_W'(1);
                if (wr_q) begin
                    if (cnt_q == WR_LAST) begin
                        state_d = StIdle;
                    end
                end else if (cnt_q == RD_LAST) begin
                    capture = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wr_q    <= req_wr;
            end
            if (capture) begin
                rdata_q <= ram_dout;
                perr_q  <= perr_now;
            end
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (capture && perr_now),
        .count (err_count)
    );

    // RAM controls are pure decodes of the state plus the latched request, so they
    // cannot change while ACCESS lasts and are all zero in IDLE/RESP.
    assign in_access      = (state_q == StAccess);
    assign ram_blk_select = in_access;
    assign ram_addr_en    = in_access;
    assign ram_wr_en      = in_access && wr_q;
    assign ram_rd_en      = in_access && !wr_q;
    assign ram_dout_en    = in_access && !wr_q;
    assign ram_addr       = in_access ? addr_q : '0;
    assign ram_din        = (in_access && wr_q) ? wdata_q : '0;

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_perr  = perr_q;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Scoreboard bench for ram_req_ctrl driving a behavioural parity RAM
// (address pipeline on, output pipeline off).
module tb_ram_req_ctrl;

    localparam int unsigned MW  = 16;
    localparam int unsigned AS  = 10;
    localparam int unsigned WRH = 3;
    localparam int unsigned RDL = 4;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wr;
    logic [AS-1:0] req_addr;
    logic [MW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_perr;
    logic [MW-1:0] rsp_rdata;
    logic [CW-1:0] err_count;
    logic          ram_blk_select, ram_wr_en, ram_rd_en, ram_addr_en, ram_dout_en;
    logic [AS-1:0] ram_addr;
    logic [MW-1:0] ram_din, ram_dout;
    logic          ram_parity;

    always #5 clk = ~clk;

    ram_req_ctrl #(
        .MEM_WIDTH  (MW),
        .ADDR_SIZE  (AS),
        .WR_HOLD    (WRH),
        .RD_LATENCY (RDL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_perr       (rsp_perr),
        .err_count      (err_count),
        .ram_blk_select (ram_blk_select),
        .ram_wr_en      (ram_wr_en),
        .ram_rd_en      (ram_rd_en),
        .ram_addr_en    (ram_addr_en),
        .ram_dout_en    (ram_dout_en),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .ram_parity     (ram_parity)
    );

    // Behavioural parity RAM.
    logic [MW-1:0] mem [1<<AS];
    logic [AS-1:0] mem_addr_q;
    logic          force_perr;

    always @(posedge clk) begin
        if (ram_blk_select && ram_addr_en) mem_addr_q <= ram_addr;
        if (ram_blk_select && ram_wr_en)   mem[ram_addr] <= ram_din;
    end
    assign ram_dout   = (ram_blk_select && ram_rd_en && ram_dout_en) ? mem[mem_addr_q] : '0;
    assign ram_parity = (^ram_dout) ^ force_perr;

    // Reference model and scoreboard.
    typedef struct {
        logic [MW-1:0] data;
        logic          perr;
        logic [CW-1:0] cnt;
        int            acc_cyc;
    } exp_t;

    exp_t          sb[$];
    logic [MW-1:0] ref_mem [1<<AS];
    logic [CW-1:0] exp_cnt;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic          hold_rsp = 1'b0;
    logic          cur_wr;
    logic [AS-1:0] cur_addr;
    logic [MW-1:0] cur_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic logic [30:0] ram_bus();
        return {ram_blk_select, ram_wr_en, ram_rd_en, ram_addr_en, ram_dout_en, ram_addr, ram_din};
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_err_count"}, 64'(err_count), 64'd0);
        check({tag, "_ram_bus"},   64'(ram_bus()), 64'd0);
    endtask

    task automatic issue(input logic wr, input logic [AS-1:0] addr, input logic [MW-1:0] data,
                         input logic fperr);
        int waited = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        while (!req_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                fail_now("issue_timeout");
                req_valid = 1'b0;
                return;
            end
        end
        force_perr = fperr;
        cur_wr     = wr;
        cur_addr   = addr;
        cur_data   = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (wr) begin
            ref_mem[addr] = data;
        end else begin
            if (fperr && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            sb.push_back('{data: ref_mem[addr], perr: fperr, cnt: exp_cnt, acc_cyc: cyc});
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 || rsp_valid || !req_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 500) begin
                fail_now("drain_timeout");
                return;
            end
        end
    endtask

    // Monitor: response scoreboard plus RAM-port protocol checks.
    int            access_len = 0;
    logic          acc_wr;
    logic [AS-1:0] acc_addr;
    logic [MW-1:0] acc_data;
    logic          prev_valid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                access_len = 0;
                prev_valid = 1'b0;
            end else begin
                if (ram_blk_select) begin
                    if (access_len == 0) begin
                        acc_wr   = cur_wr;
                        acc_addr = cur_addr;
                        acc_data = cur_data;
                    end
                    access_len++;
                    check("ram_access_bus", 64'(ram_bus()),
                          64'({1'b1, acc_wr, !acc_wr, 1'b1, !acc_wr, acc_addr,
                               acc_wr ? acc_data : {MW{1'b0}}}));
                    check("req_ready_in_access", 64'(req_ready), 64'd0);
                end else begin
                    if (access_len != 0) begin
                        check("access_len", 64'(access_len), acc_wr ? 64'(WRH) : 64'(RDL));
                        access_len = 0;
                    end
                    check("ram_idle_bus", 64'(ram_bus()), 64'd0);
                end
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        fail_now("spurious_response");
                    end else begin
                        check("rsp_rdata", 64'(rsp_rdata), 64'(sb[0].data));
                        check("rsp_perr",  64'(rsp_perr),  64'(sb[0].perr));
                        check("err_count", 64'(err_count), 64'(sb[0].cnt));
                        check("req_ready_in_resp", 64'(req_ready), 64'd0);
                        if (!prev_valid)
                            check("rd_latency", 64'(cyc - sb[0].acc_cyc), 64'(RDL));
                        if (rsp_ready) void'(sb.pop_front());
                    end
                end
                prev_valid = rsp_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int waited;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        force_perr = 1'b0;
        exp_cnt    = '0;
        cur_wr     = 1'b0;
        cur_addr   = '0;
        cur_data   = '0;
        for (int i = 0; i < (1 << AS); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // 1. Reset
        repeat (3) @(negedge clk);
        check_reset_state("rst_held");
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst_released");

        // 2. Write then read back
        issue(1'b1, 10'h005, 16'hA5A5, 1'b0);
        issue(1'b0, 10'h005, '0, 1'b0);
        drain();

        // 3. Two forced parity errors
        issue(1'b0, 10'h005, '0, 1'b1);
        issue(1'b0, 10'h005, '0, 1'b1);
        drain();
        check("err_count_after_two", 64'(err_count), 64'd2);

        // 4. Response back-pressure
        hold_rsp = 1'b1;
        issue(1'b0, 10'h005, '0, 1'b0);
        waited = 0;
        while (!rsp_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("hold_reached_resp", 64'(rsp_valid), 64'd1);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 10'h123;
        req_wdata = 16'hDEAD;
        repeat (10) begin
            @(negedge clk);
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_no_access", 64'(ram_blk_select), 64'd0);
        end
        req_valid = 1'b0;
        hold_rsp  = 1'b0;
        drain();

        // 5. Address extremes
        issue(1'b1, 10'h3FF, 16'hFFFF, 1'b0);
        issue(1'b1, 10'h000, 16'h0001, 1'b0);
        issue(1'b0, 10'h3FF, '0, 1'b0);
        issue(1'b0, 10'h000, '0, 1'b0);
        drain();

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            logic          wr;
            logic [AS-1:0] a;
            wr = 1'($urandom_range(0, 1));
            a  = AS'($urandom_range(0, 15));
            issue(wr, a, MW'($urandom), !wr && ($urandom_range(0, 3) == 0));
        end
        drain();

        // Drive the error counter into saturation
        for (int i = 0; i < 18; i++) begin
            issue(1'b0, AS'($urandom), '0, 1'b1);
        end
        drain();
        check("err_count_saturated", 64'(err_count), 64'((1 << CW) - 1));

        // 6. Reset in the middle of a read access
        issue(1'b0, 10'h3FF, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mid_access", 64'(ram_blk_select), 64'd1);
        rst = 1'b0;
        sb.delete();
        exp_cnt = '0;
        @(negedge clk);
        check_reset_state("rst_mid_read");
        rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("no_spurious_rsp", 64'(rsp_valid), 64'd0);
        end
        check("err_count_post_reset", 64'(err_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
